data_mem_responder: RTL and testbench

- Memory-side responder for the load/store requests the pipeline's MEM stage issues.
- Accepts one word request per valid/ready handshake, performs the read or write against a local word array, and returns a one-cycle response a fixed LATENCY cycles after acceptance.
- Replaces the zero-latency data memory so the pipeline can be exercised against multi-cycle memory and stall logic.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/dmem_array.sv | 31 +++
 rtl/data_mem_responder.sv | 122 ++++++++++++
 tb/tb_data_mem_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the data-memory responder.
// Latency: n/a (types only).
// Backpressure: n/a.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_WORD_BYTES = 4;
    localparam int DMEM_LAT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH_WORDS x 32 synchronous RAM with write enable and registered read.
// Latency: read data valid one cycle after a read-enabled edge; writes commit at the edge.
// Backpressure: none; one access per cycle.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Contents and read register are deliberately unreset so this maps to a plain RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Word load/store responder; DMEM_ADDR_CHECK_EN enables misalign/range error checking.
// Latency: response strobe exactly LATENCY cycles after the accept edge.
// Backpressure: req_ready low while a response is pending (WAIT); no backpressure on rsp.
module data_mem_responder
    import pipeline_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_busy
);

    localparam int AW  = $clog2(DEPTH_WORDS);
    localparam int OFF = $clog2(DMEM_WORD_BYTES);
    localparam logic [DMEM_LAT_W-1:0] CNT_LOAD = DMEM_LAT_W'(LATENCY - 1);
    localparam logic [DMEM_LAT_W-1:0] CNT_ONE  = DMEM_LAT_W'(1);
    localparam dmem_state_t ACC_NEXT = (LATENCY == 1) ? RESP : WAIT;

    dmem_state_t           state_q, state_d;
    logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic                  live_q;

    logic                  accept;
    logic                  addr_err;
    logic                  ram_we;
    logic                  ram_re;
    logic [AW-1:0]         word_idx;
    logic [31:0]           ram_rdata;

    assign word_idx = req_addr[AW+OFF-1:OFF];

`ifdef DMEM_ADDR_CHECK_EN
    assign addr_err = (req_addr[OFF-1:0] != '0) || (req_addr[31:AW+OFF] != '0);
`else
    // Offset and high bits are ignored: the word index wraps modulo DEPTH_WORDS.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[OFF-1:0], req_addr[31:AW+OFF]};
    assign addr_err         = 1'b0;
`endif

    // live_q keeps req_ready low while reset is asserted even though state is IDLE.
    assign req_ready = live_q && (state_q != WAIT);
    assign accept    = req_valid && req_ready;
    assign ram_we    = accept && req_write && !addr_err;
    assign ram_re    = accept && !req_write && !addr_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (word_idx),
        .wdata_i (req_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    state_d = ACC_NEXT;
                    cnt_d   = CNT_LOAD;
                    wr_d    = req_write;
                    err_d   = addr_err;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    // The RAM read register holds the load data captured at the accept edge until the next load.
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !wr_q && !err_q) ? ram_rdata : 32'h0;
    assign mem_busy  = (state_q == WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with LATENCY=2, DEPTH_WORDS=256.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS (256),
        .LATENCY     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_busy  (mem_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with req_ready expected high; returns at the negedge of the response cycle.
    task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
        int n;
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        if (!rsp_valid) chk({tag, "_busy"}, {31'b0, mem_busy}, 32'd1);
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, 32'd2);
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    endtask

    initial begin
        logic [31:0] exp10;
        logic [4:0]  rdy_pat;
        logic [4:0]  busy_pat;
        int          acc;
        int          seen;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_busy", {31'b0, mem_busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);

        // Store then back-to-back load accepted in the store's response cycle.
        txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

`ifdef DMEM_ADDR_CHECK_EN
        txn("st13", 1'b1, 32'h13, 32'h12345678, 32'h0, 1'b1);
        exp10 = 32'hDEADBEEF;
        txn("ld10b", 1'b0, 32'h10, 32'h0, exp10, 1'b0);
        txn("ld400", 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
`else
        // Without checking, 0x13 aliases word 4 (address 0x10).
        txn("st13", 1'b1, 32'h13, 32'h12345678, 32'h0, 1'b0);
        exp10 = 32'h12345678;
        txn("ld10b", 1'b0, 32'h10, 32'h0, exp10, 1'b0);
        txn("st400", 1'b1, 32'h400, 32'hA5A5A5A5, 32'h0, 1'b0);
        txn("ld0", 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
`endif

        // Let the last response retire to IDLE.
        @(negedge clk);
        chk("idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);

        // Constant load held valid across four cycles.
        rdy_pat  = 5'b10101;
        busy_pat = 5'b01010;
        acc      = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req_valid = 1'b0;
            chk($sformatf("hold_ready_%0d", k), {31'b0, req_ready}, {31'b0, rdy_pat[k]});
            chk($sformatf("hold_busy_%0d", k), {31'b0, mem_busy}, {31'b0, busy_pat[k]});
            if (k == 2 || k == 4) begin
                chk($sformatf("hold_rsp_%0d", k), {31'b0, rsp_valid}, 32'd1);
                chk($sformatf("hold_rdata_%0d", k), rsp_rdata, exp10);
            end
            if (req_valid && req_ready) acc++;
            @(negedge clk);
        end
        chk("hold_accepts", acc, 32'd2);
        chk("hold_end_rsp_valid", {31'b0, rsp_valid}, 32'd0);

        // Reset while a load is pending drops its response.
        req_valid = 1'b1;
        req_addr  = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, req_ready}, 32'd0);
        chk("midrst_busy", {31'b0, mem_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("midrst_no_rsp", seen, 32'd0);
        chk("midrst_ready_after", {31'b0, req_ready}, 32'd1);
        txn("ld10c", 1'b0, 32'h10, 32'h0, exp10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
